// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART TX line feeder.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_CR   = 3'd3,
        ST_LF   = 3'd4
    } t_uarttxline_state;

    localparam logic [7:0] c_ascii_cr = 8'h0D;
    localparam logic [7:0] c_ascii_lf = 8'h0A;

endpackage

// File: rtl/uart_tx_line_sender_if.sv
// Line request handshake plus transmitter write port of the line feeder.
interface uart_tx_line_sender_if #(
    parameter int unsigned L = 35
);
    logic [8*L-1:0] i_dat_ascii_line;
    logic           i_line_valid;
    logic           o_line_ready;
    logic           o_line_sent;
    logic [7:0]     o_tx_data;
    logic           o_tx_valid;
    logic           i_tx_ready;

    // Feeder side.
    modport slave (
        input  i_dat_ascii_line,
        input  i_line_valid,
        input  i_tx_ready,
        output o_line_ready,
        output o_line_sent,
        output o_tx_data,
        output o_tx_valid
    );

    // Line producer / transmitter side.
    modport master (
        output i_dat_ascii_line,
        output i_line_valid,
        output i_tx_ready,
        input  o_line_ready,
        input  o_line_sent,
        input  o_tx_data,
        input  o_tx_valid
    );
endinterface

// File: rtl/uart_tx_line_sender.sv
// Streams one fixed-length ASCII line plus CR LF into the UART TX write port.
module uart_tx_line_sender
    import uart_tx_pkg::*;
#(
    parameter int unsigned parm_ascii_line_length = 35
) (
    input  logic                  i_clk_40mhz,
    input  logic                  i_rst_40mhz,
    uart_tx_line_sender_if.slave  bus
);

    localparam int unsigned L  = parm_ascii_line_length;
    localparam int unsigned LW = 8 * L;
    localparam int unsigned CW = $clog2(L + 1);

    t_uarttxline_state state_q, state_d;
    logic [LW-1:0]     shift_q, shift_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic       tx_valid_q, tx_valid_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       line_sent_q, line_sent_d;
    logic       line_ready_q, line_ready_d;

    // State, captured line and byte counter.
    always_ff @(posedge i_clk_40mhz) begin
        if (i_rst_40mhz) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and Moore output decode; outputs lag the state by one register.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        tx_valid_d = 1'b0;
        tx_data_d  = tx_data_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.i_line_valid && line_ready_q) begin
                    state_d = ST_WAIT;
                    shift_d = bus.i_dat_ascii_line;
                end
            end
            ST_WAIT: begin
                // Room for a whole line is checked once; later drops are ignored.
                if (bus.i_tx_ready) begin
                    state_d = ST_DATA;
                    cnt_d   = '0;
                end
            end
            ST_DATA: begin
                tx_valid_d = 1'b1;
                tx_data_d  = shift_q[LW-1 -: 8];
                shift_d    = shift_q << 8;
                cnt_d      = cnt_q + CW'(1);
                if (cnt_q == CW'(L - 1)) begin
                    state_d = ST_CR;
                end
            end
            ST_CR: begin
                tx_valid_d = 1'b1;
                tx_data_d  = c_ascii_cr;
                state_d    = ST_LF;
            end
            ST_LF: begin
                tx_valid_d = 1'b1;
                tx_data_d  = c_ascii_lf;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Ready is shown only for an idle state that is not being left this cycle.
        line_ready_d = (state_q == ST_IDLE) && (state_d == ST_IDLE);
        // The LF write is the only valid byte that can precede an idle state.
        line_sent_d  = (state_q == ST_IDLE) && tx_valid_q;
    end

    // Output registers.
    always_ff @(posedge i_clk_40mhz) begin
        if (i_rst_40mhz) begin
            tx_valid_q   <= 1'b0;
            tx_data_q    <= 8'h00;
            line_sent_q  <= 1'b0;
            line_ready_q <= 1'b0;
        end else begin
            tx_valid_q   <= tx_valid_d;
            tx_data_q    <= tx_data_d;
            line_sent_q  <= line_sent_d;
            line_ready_q <= line_ready_d;
        end
    end

    assign bus.o_tx_valid   = tx_valid_q;
    assign bus.o_tx_data    = tx_data_q;
    assign bus.o_line_sent  = line_sent_q;
    assign bus.o_line_ready = line_ready_q;

endmodule

// File: tb/tb_uart_tx_line_sender.sv
// Directed + randomized bench for uart_tx_line_sender (L=35 and L=4 instances).
module tb_uart_tx_line_sender;

    localparam int LA = 35;
    localparam int LB = 4;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    uart_tx_line_sender_if #(.L(LA)) ifa ();
    uart_tx_line_sender_if #(.L(LB)) ifb ();

    uart_tx_line_sender #(.parm_ascii_line_length(LA)) dut_a (
        .i_clk_40mhz (clk),
        .i_rst_40mhz (rst),
        .bus         (ifa)
    );

    uart_tx_line_sender #(.parm_ascii_line_length(LB)) dut_b (
        .i_clk_40mhz (clk),
        .i_rst_40mhz (rst),
        .bus         (ifb)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference stream: the line's characters left to right, then CR, LF.
    function automatic logic [7:0] exp_a(input logic [8*LA-1:0] line, input int i);
        if (i < LA) return line[8*(LA-1-i) +: 8];
        return (i == LA) ? 8'h0D : 8'h0A;
    endfunction

    function automatic logic [7:0] exp_b(input logic [8*LB-1:0] line, input int i);
        if (i < LB) return line[8*(LB-1-i) +: 8];
        return (i == LB) ? 8'h0D : 8'h0A;
    endfunction

    // One line on instance A: wait delay cycles with ready low, optional busy
    // request, optional mid-line ready drop, optional reset after byte abort_at.
    task automatic send_a(input logic [8*LA-1:0] line, input int delay,
                          input int abort_at, input bit busy, input bit drop);
        check("a_ready_before_req", ifa.o_line_ready, 1);
        ifa.i_dat_ascii_line = line;
        ifa.i_line_valid     = 1'b1;
        ifa.i_tx_ready       = (delay == 0);
        tick();
        ifa.i_line_valid = 1'b0;
        check("a_ready_low_after_accept", ifa.o_line_ready, 0);
        for (int d = 0; d < delay; d++) begin
            check("a_no_valid_while_blocked", ifa.o_tx_valid, 0);
            tick();
        end
        ifa.i_tx_ready = 1'b1;
        check("a_no_valid_before_sample", ifa.o_tx_valid, 0);
        tick();
        check("a_no_valid_after_sample", ifa.o_tx_valid, 0);
        tick();
        for (int i = 0; i < LA + 2; i++) begin
            check("a_valid", ifa.o_tx_valid, 1);
            check("a_data", ifa.o_tx_data, exp_a(line, i));
            check("a_no_sent_mid", ifa.o_line_sent, 0);
            if (i == abort_at) begin
                rst = 1'b1;
                tick();
                check("a_rst_valid", ifa.o_tx_valid, 0);
                check("a_rst_ready", ifa.o_line_ready, 0);
                check("a_rst_data", ifa.o_tx_data, 8'h00);
                rst = 1'b0;
                tick();
                check("a_ready_after_release", ifa.o_line_ready, 1);
                check("a_valid_after_release", ifa.o_tx_valid, 0);
                return;
            end
            if (busy && i == 3) begin
                ifa.i_dat_ascii_line = ~line;
                ifa.i_line_valid     = 1'b1;
                check("a_ready_low_busy", ifa.o_line_ready, 0);
            end
            if (busy && i == 5) ifa.i_line_valid = 1'b0;
            if (drop && i == 6) ifa.i_tx_ready = 1'b0;
            if (drop && i == 12) ifa.i_tx_ready = 1'b1;
            tick();
        end
        check("a_valid_end", ifa.o_tx_valid, 0);
        check("a_sent_pulse", ifa.o_line_sent, 1);
        check("a_ready_with_sent", ifa.o_line_ready, 1);
        check("a_data_hold", ifa.o_tx_data, 8'h0A);
        tick();
        check("a_sent_one_cycle", ifa.o_line_sent, 0);
        check("a_valid_idle", ifa.o_tx_valid, 0);
        check("a_ready_idle", ifa.o_line_ready, 1);
    endtask

    initial begin
        logic [8*LA-1:0] basic;
        logic [8*LA-1:0] rnd;
        logic [8*LB-1:0] lb1;
        logic [8*LB-1:0] lb2;
        logic            ev;
        logic            es;
        logic [7:0]      ed;
        bit              req2;
        int              s1, sent1, s2, sent2;

        basic = "0123456789ABCDEFGHIJKLMNOPQRSTUVWXY";
        lb1   = "ABCD";
        lb2   = "WXYZ";

        rst                  = 1'b1;
        ifa.i_dat_ascii_line = '0;
        ifa.i_line_valid     = 1'b0;
        ifa.i_tx_ready       = 1'b1;
        ifb.i_dat_ascii_line = '0;
        ifb.i_line_valid     = 1'b0;
        ifb.i_tx_ready       = 1'b1;
        tick();
        tick();
        check("rst_ready", ifa.o_line_ready, 0);
        check("rst_valid", ifa.o_tx_valid, 0);
        check("rst_data", ifa.o_tx_data, 8'h00);
        check("rst_sent", ifa.o_line_sent, 0);
        rst = 1'b0;
        tick();
        check("ready_after_reset_a", ifa.o_line_ready, 1);
        check("ready_after_reset_b", ifb.o_line_ready, 1);

        // Basic line, backpressure with mid-line drop, busy request, reset mid-line.
        send_a(basic, 0, -1, 1'b0, 1'b0);
        send_a(basic, 50, -1, 1'b0, 1'b1);
        send_a(basic, 0, -1, 1'b1, 1'b0);
        send_a(basic, 0, 10, 1'b0, 1'b0);
        send_a(basic, 0, -1, 1'b0, 1'b0);

        // Random lines, including a NUL byte, with random wait delays.
        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < LA; j++) rnd[8*j +: 8] = 8'($urandom);
            rnd[8*$urandom_range(0, LA-1) +: 8] = 8'h00;
            send_a(rnd, int'($urandom_range(0, 4)), -1, 1'b0, bit'($urandom_range(0, 1)));
        end

        // Back-to-back on L=4: second request raised in the o_line_sent cycle.
        req2 = 1'b0;
        ifb.i_dat_ascii_line = lb1;
        ifb.i_line_valid     = 1'b1;
        check("b_ready_before_req", ifb.o_line_ready, 1);
        tick();
        ifb.i_line_valid = 1'b0;
        s1    = 2;
        sent1 = s1 + LB + 2;
        s2    = sent1 + 1 + 2;
        sent2 = s2 + LB + 2;
        for (int c = 0; c <= sent2 + 1; c++) begin
            ev = ((c >= s1) && (c < sent1)) || ((c >= s2) && (c < sent2));
            es = (c == sent1) || (c == sent2);
            ed = ((c >= s2) && (c < sent2)) ? exp_b(lb2, c - s2) :
                 ((c >= s1) && (c < sent1)) ? exp_b(lb1, c - s1) : 8'h00;
            check("b_valid", ifb.o_tx_valid, ev);
            if (ev) check("b_data", ifb.o_tx_data, ed);
            check("b_sent", ifb.o_line_sent, es);
            if (ifb.o_line_sent && !req2) begin
                ifb.i_dat_ascii_line = lb2;
                ifb.i_line_valid     = 1'b1;
                req2                 = 1'b1;
            end else begin
                ifb.i_line_valid = 1'b0;
            end
            tick();
        end
        check("b_second_request_made", req2, 1);
        check("b_ready_end", ifb.o_line_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
